// File: rtl/mastermind_pkg.sv
// ----------------------------------------------------------------------------
// mastermind_pkg
// Shared definitions for the Mastermind game controller:
//   - code geometry (colour width, slot count, packed code width)
//   - special colour values (none / fallback)
//   - one-hot FSM state encoding
//   - button index map for the conditioned-button vector
//   - LFSR tap mask and single-step helper
// ----------------------------------------------------------------------------
package mastermind_pkg;

    localparam int COLOR_W = 3;
    localparam int SLOTS   = 4;
    localparam int CODE_W  = COLOR_W * SLOTS;

    localparam logic [COLOR_W-1:0] COLOR_NONE     = 3'd0;
    localparam logic [COLOR_W-1:0] COLOR_FALLBACK = 3'd1;

    // Fibonacci taps 16,14,13,11 -> register bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Index of each board button inside the conditioned-button vector.
    localparam int BTN_C    = 0;
    localparam int BTN_U    = 1;
    localparam int BTN_L    = 2;
    localparam int BTN_R    = 3;
    localparam int BTN_D    = 4;
    localparam int NUM_BTNS = 5;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_GEN    = 5'b00010,
        ST_LOAD   = 5'b00100,
        ST_PLAY   = 5'b01000,
        ST_RESULT = 5'b10000
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// ----------------------------------------------------------------------------
// btn_conditioner
// Turns one raw board button into a clean single-cycle press pulse:
// 2-flop synchronizer, optional debounce filter, rising-edge detector.
// Holding the button yields exactly one pulse.
//
// Build option: DEBOUNCE_EN
//   defined   - level accepted only after DEBOUNCE_CYCLES identical samples
//   undefined - synchronizer + edge detect only (raw-to-pulse 2 cycles)
//
// Ports:
//   Clk       in  system clock
//   Reset_n   in  asynchronous active-low reset
//   btn_raw   in  raw, bouncing, asynchronous button level
//   btn_pulse out one-cycle pulse on each accepted press
// ----------------------------------------------------------------------------
module btn_conditioner
`ifdef DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 250000
)
`endif
(
    input  logic Clk,
    input  logic Reset_n,
    input  logic btn_raw,
    output logic btn_pulse
);

    logic sync_1;
    logic sync_2;
    logic level;
    logic level_d;

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge value of its neighbours, regardless of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] stable_cnt;
    logic             level_q;

    // The counter runs only while the synchronized sample disagrees with the
    // accepted level; any agreeing sample (a bounce back) restarts it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            level_q    <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_2 == level_q) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_q    <= sync_2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    assign level = level_q;
`else
    assign level = sync_2;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign btn_pulse = level & ~level_d;

endmodule

// File: rtl/mastermind_game_ctrl.sv
// ----------------------------------------------------------------------------
// mastermind_game_ctrl
// Sequencer in front of mastermind_core: conditions the five board buttons,
// draws a random 4-colour secret from a free-running LFSR, resets/launches
// the core per game and keeps saturating win/loss tallies.
//
// Build option: DEBOUNCE_EN (see btn_conditioner).
//
// Ports:
//   Clk, Reset_n                   clock, asynchronous active-low reset
//   BtnC/U/L/R/D_raw               raw buttons (confirm, check, left, right, new game)
//   q_Start, q_DoneC, q_DoneNC     core status flags (START, solved, out of guesses)
//   core_reset                     active-high core reset (high except PLAY/RESULT)
//   correct_answer[11:0]           secret code, slot0 = [2:0]
//   confirm_color, check_guess,
//   BtnL, BtnR                     one-cycle pulses to the core, PLAY only
//   wins[3:0], losses[3:0]         saturating tallies
//   game_active                    high in PLAY
// ----------------------------------------------------------------------------
module mastermind_game_ctrl
    import mastermind_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int          GEN_MAX_CYCLES  = 64
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              BtnC_raw,
    input  logic              BtnU_raw,
    input  logic              BtnL_raw,
    input  logic              BtnR_raw,
    input  logic              BtnD_raw,
    input  logic              q_Start,
    input  logic              q_DoneC,
    input  logic              q_DoneNC,
    output logic              core_reset,
    output logic [CODE_W-1:0] correct_answer,
    output logic              confirm_color,
    output logic              check_guess,
    output logic              BtnL,
    output logic              BtnR,
    output logic [3:0]        wins,
    output logic [3:0]        losses,
    output logic              game_active
);

    localparam logic [15:0] LFSR_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam int          GCNT_W    = $clog2(GEN_MAX_CYCLES + 1);

    logic [NUM_BTNS-1:0] btn_raw_vec;
    logic [NUM_BTNS-1:0] btn_pulse;

    assign btn_raw_vec = {BtnD_raw, BtnR_raw, BtnL_raw, BtnU_raw, BtnC_raw};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
`ifdef DEBOUNCE_EN
        btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
`else
        btn_conditioner u_cond (
`endif
            .Clk      (Clk),
            .Reset_n  (Reset_n),
            .btn_raw  (btn_raw_vec[i]),
            .btn_pulse(btn_pulse[i])
        );
    end

    state_t               state;
    state_t               state_next;
    logic [15:0]          lfsr;
    logic [2:0]           gen_idx;
    logic [2:0]           gen_idx_next;
    logic [GCNT_W-1:0]    gen_cnt;
    logic [COLOR_W-1:0]   slot_buf [SLOTS];
    logic [3:0]           fwd_q;
    logic [3:0]           fwd_gated;
    logic                 gen_write;
    logic                 gen_last;
    logic                 gen_timeout;
    logic                 done_c;
    logic                 done_nc;

    // Done flags are stale while the core still reports START.
    assign done_c  = q_DoneC  & ~q_Start;
    assign done_nc = q_DoneNC & ~q_Start;

    assign gen_write    = (lfsr[COLOR_W-1:0] != COLOR_NONE);
    assign gen_idx_next = gen_idx + {2'b00, gen_write};
    assign gen_last     = gen_write && (gen_idx == 3'(SLOTS - 1));
    assign gen_timeout  = (gen_cnt == GCNT_W'(GEN_MAX_CYCLES - 1));

    // Free-running in every state so the press timing seeds the draw.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lfsr <= LFSR_INIT;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (btn_pulse[BTN_D]) state_next = ST_GEN;
            ST_GEN:    if (gen_last || gen_timeout) state_next = ST_LOAD;
            ST_LOAD:   state_next = ST_PLAY;
            // A done flag outranks an abandon press in the same cycle.
            ST_PLAY: begin
                if (done_c || done_nc)      state_next = ST_RESULT;
                else if (btn_pulse[BTN_D])  state_next = ST_GEN;
            end
            ST_RESULT: if (btn_pulse[BTN_D]) state_next = ST_GEN;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        core_reset  = 1'b1;
        game_active = 1'b0;
        fwd_gated   = '0;
        case (state)
            ST_PLAY: begin
                core_reset  = 1'b0;
                game_active = 1'b1;
                fwd_gated   = fwd_q;
            end
            ST_RESULT: core_reset = 1'b0;
            default: ;
        endcase
    end

    assign confirm_color = fwd_gated[BTN_C];
    assign check_guess   = fwd_gated[BTN_U];
    assign BtnL          = fwd_gated[BTN_L];
    assign BtnR          = fwd_gated[BTN_R];

    // NOTE: the slot buffer is only four 3-bit registers, so it is reset
    // along with everything else rather than treated as an unreset RAM.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            gen_idx        <= '0;
            gen_cnt        <= '0;
            fwd_q          <= '0;
            correct_answer <= '0;
            wins           <= '0;
            losses         <= '0;
            for (int i = 0; i < SLOTS; i++) slot_buf[i] <= COLOR_NONE;
        end else begin
            fwd_q <= (state == ST_PLAY) ? btn_pulse[BTN_R:BTN_C] : 4'b0000;

            if (state != ST_GEN && state_next == ST_GEN) begin
                gen_idx <= '0;
                gen_cnt <= '0;
            end else if (state == ST_GEN) begin
                gen_cnt <= gen_cnt + 1'b1;
                if (gen_write) begin
                    slot_buf[gen_idx[1:0]] <= lfsr[COLOR_W-1:0];
                    gen_idx                <= gen_idx_next;
                end
                // Out of budget: every slot not yet written gets the fallback.
                if (gen_timeout) begin
                    for (int i = 0; i < SLOTS; i++) begin
                        if (i >= int'(gen_idx_next)) slot_buf[i] <= COLOR_FALLBACK;
                    end
                end
            end

            if (state == ST_LOAD) begin
                for (int i = 0; i < SLOTS; i++) correct_answer[i*COLOR_W +: COLOR_W] <= slot_buf[i];
            end

            if (state == ST_PLAY) begin
                if (done_c) begin
                    if (wins != 4'd15) wins <= wins + 4'd1;
                end else if (done_nc || btn_pulse[BTN_D]) begin
                    if (losses != 4'd15) losses <= losses + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mastermind_game_ctrl
// Directed game sequence with randomized button choices, checked against a
// reference model of the secret-code draw and the tally rules.
// ----------------------------------------------------------------------------
module tb_mastermind_game_ctrl;

    localparam int          DBC  = 4;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          GMAX = 64;
    localparam int          HOLD = 10;
`ifdef DEBOUNCE_EN
    localparam int PRESS_LAT = 3 + DBC;
`else
    localparam int PRESS_LAT = 3;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [4:0]  btn_raw;
    logic        q_Start, q_DoneC, q_DoneNC;
    logic        core_reset, confirm_color, check_guess, BtnL, BtnR, game_active;
    logic [11:0] correct_answer;
    logic [3:0]  wins, losses;
    logic [3:0]  pulses_obs;

    int n_pass  = 0;
    int n_total = 0;
    int cyc;
    int exp_wins   = 0;
    int exp_losses = 0;
    logic [11:0] last_code = '0;

    mastermind_game_ctrl #(
        .DEBOUNCE_CYCLES(DBC),
        .LFSR_SEED      (SEED),
        .GEN_MAX_CYCLES (GMAX)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .BtnC_raw      (btn_raw[0]),
        .BtnU_raw      (btn_raw[1]),
        .BtnL_raw      (btn_raw[2]),
        .BtnR_raw      (btn_raw[3]),
        .BtnD_raw      (btn_raw[4]),
        .q_Start       (q_Start),
        .q_DoneC       (q_DoneC),
        .q_DoneNC      (q_DoneNC),
        .core_reset    (core_reset),
        .correct_answer(correct_answer),
        .confirm_color (confirm_color),
        .check_guess   (check_guess),
        .BtnL          (BtnL),
        .BtnR          (BtnR),
        .wins          (wins),
        .losses        (losses),
        .game_active   (game_active)
    );

    assign pulses_obs = {BtnR, BtnL, check_guess, confirm_color};

    always #5 Clk = ~Clk;

    // Clock edges seen since reset release; the LFSR has stepped this often.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic fb;
        fb = x[15] ^ x[13] ^ x[12] ^ x[10];
        return {x[14:0], fb};
    endfunction

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // Draw model: GEN starts after `edges` LFSR steps; keep nonzero low
    // triplets until four are collected or the budget runs out.
    task automatic model_gen(input int edges, output logic [11:0] code, output int m);
        logic [15:0] x;
        int n;
        x = SEED;
        for (int i = 0; i < edges; i++) x = lfsr_step(x);
        code = '0;
        n = 0;
        m = GMAX;
        for (int j = 0; j < GMAX; j++) begin
            if (x[2:0] != 3'd0) begin
                code[n*3 +: 3] = x[2:0];
                n++;
                if (n == 4) begin
                    m = j + 1;
                    break;
                end
            end
            x = lfsr_step(x);
        end
        for (int k = n; k < 4; k++) code[k*3 +: 3] = 3'd1;
    endtask

    // Press BtnD from IDLE, PLAY or RESULT and follow GEN -> LOAD -> PLAY.
    task automatic new_game(input string tag, input bit abandon);
        logic [11:0] exp_code;
        int m, c0, last;
        q_DoneC  = 1'b0;
        q_DoneNC = 1'b0;
        btn_raw[4] = 1'b1;
        c0 = cyc;
        model_gen(c0 + PRESS_LAT, exp_code, m);
        last = PRESS_LAT + m + 1;
        if (abandon) exp_losses = sat15(exp_losses + 1);
        for (int k = 1; k <= last; k++) begin
            @(negedge Clk);
            if (k == HOLD) btn_raw[4] = 1'b0;
            if (k == PRESS_LAT + m) check({tag, "_load_core_reset"}, core_reset, 1'b1);
        end
        check({tag, "_play_core_reset"}, core_reset, 1'b0);
        check({tag, "_play_active"}, game_active, 1'b1);
        check({tag, "_code"}, correct_answer, exp_code);
        check({tag, "_losses"}, losses, exp_losses);
        last_code = exp_code;
        q_Start = 1'b0;
        for (int k = last + 1; k <= 2 * HOLD; k++) begin
            @(negedge Clk);
            if (k == HOLD) btn_raw[4] = 1'b0;
        end
    endtask

    // Press one of C/U/L/R and check the forwarded pulse vector every cycle.
    task automatic press_check(input int b, input int hold, input bit exp_pulse, input string tag);
        logic [3:0] exp;
        btn_raw[b] = 1'b1;
        for (int k = 1; k <= hold + PRESS_LAT + 2; k++) begin
            @(negedge Clk);
            if (k == hold) btn_raw[b] = 1'b0;
            exp = (exp_pulse && k == PRESS_LAT) ? 4'(1 << b) : 4'b0000;
            check(tag, pulses_obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_code"}, correct_answer, 12'h000);
        check({tag, "_wins"}, wins, 4'd0);
        check({tag, "_losses"}, losses, 4'd0);
        check({tag, "_core_reset"}, core_reset, 1'b1);
        check({tag, "_active"}, game_active, 1'b0);
        check({tag, "_pulses"}, pulses_obs, 4'b0000);
    endtask

    initial begin
        int c0;
        Reset_n  = 1'b0;
        btn_raw  = '0;
        q_Start  = 1'b1;
        q_DoneC  = 1'b0;
        q_DoneNC = 1'b0;
        repeat (3) @(negedge Clk);
        check_reset_values("reset");
        Reset_n = 1'b1;

        // Buttons other than BtnD are ignored while idle.
        press_check(int'($urandom_range(0, 3)), HOLD, 1'b0, "idle_gate");
        repeat (HOLD) @(negedge Clk);

        new_game("game1", 1'b0);

`ifdef DEBOUNCE_EN
        press_check(0, 3, 1'b0, "short_press");
        repeat (HOLD) @(negedge Clk);
`endif
        press_check(0, HOLD, 1'b1, "confirm_hold");
        for (int i = 0; i < 4; i++) press_check(int'($urandom_range(0, 3)), HOLD, 1'b1, "play_fwd");

        // Win: tally, RESULT, code held, buttons gated.
        q_DoneC = 1'b1;
        exp_wins = sat15(exp_wins + 1);
        @(negedge Clk);
        check("win_wins", wins, exp_wins);
        check("win_active", game_active, 1'b0);
        check("win_core_reset", core_reset, 1'b0);
        for (int i = 0; i < 3; i++) press_check(int'($urandom_range(0, 3)), HOLD, 1'b0, "result_gate");
        check("result_code_held", correct_answer, last_code);

        new_game("game2", 1'b0);
        new_game("abandon1", 1'b1);

        // Done and abandon press land in the same PLAY cycle: win counts.
        btn_raw[4] = 1'b1;
        c0 = cyc;
        exp_wins = sat15(exp_wins + 1);
        for (int k = 1; k <= HOLD; k++) begin
            @(negedge Clk);
            if (k == PRESS_LAT - 1) q_DoneC = 1'b1;
            if (k == PRESS_LAT) begin
                check("simul_wins", wins, exp_wins);
                check("simul_losses", losses, exp_losses);
                check("simul_active", game_active, 1'b0);
                check("simul_core_reset", core_reset, 1'b0);
            end
        end
        btn_raw[4] = 1'b0;
        repeat (HOLD) @(negedge Clk);
        check("simul_still_result", core_reset, 1'b0);
        check("simul_window", cyc - c0, 2 * HOLD);

        // Sixteen losses saturate the tally at 15.
        for (int g = 0; g < 16; g++) begin
            new_game("loss_game", 1'b0);
            q_DoneNC = 1'b1;
            exp_losses = sat15(exp_losses + 1);
            @(negedge Clk);
            check("loss_losses", losses, exp_losses);
            check("loss_active", game_active, 1'b0);
        end
        check("loss_saturated", losses, 4'd15);

        new_game("pre_abandon", 1'b0);
        new_game("abandon_sat", 1'b1);
        check("abandon_sat_wins", wins, exp_wins);

        // Reset in the middle of GEN.
        btn_raw[4] = 1'b1;
        q_Start = 1'b1;
        repeat (PRESS_LAT + 1) @(negedge Clk);
        check("mid_gen_core_reset_pre", core_reset, 1'b1);
        Reset_n = 1'b0;
        btn_raw = '0;
        #1;
        check_reset_values("mid_gen_reset");
        @(negedge Clk);
        check_reset_values("mid_gen_reset_held");
        exp_wins   = 0;
        exp_losses = 0;
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);

        new_game("after_reset", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
